prog_counter_timer: RTL

//   Parametrised loadable counter/timer; next generation of the 8-bit program counter in the

---
 rtl/prog_counter_timer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/prog_counter_timer.sv
// Loadable counter/timer with prescaler, four run modes, terminal-count pulse,
// sticky overflow flag and one-shot done flag. All outputs are registered.
module prog_counter_timer #(
    parameter int WIDTH    = 8,
    parameter int TOP      = 255,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [1:0]       mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] TOP_V    = WIDTH'(TOP);
    localparam logic [WIDTH-1:0] ZERO_V   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
    localparam logic [PSC_W-1:0] PSC_ZERO = {PSC_W{1'b0}};
    localparam logic [PSC_W-1:0] PSC_ONE  = {{(PSC_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] MODE_UP_WRAP   = 2'b00;
    localparam logic [1:0] MODE_DOWN_WRAP = 2'b01;
    localparam logic [1:0] MODE_UP_SAT    = 2'b10;
    localparam logic [1:0] MODE_ONESHOT   = 2'b11;

    logic [WIDTH-1:0] r_count;
    logic [PSC_W-1:0] r_psc;
    logic             r_tc;
    logic             r_ovf;
    logic             r_done;

    logic             w_tick;
    logic [WIDTH-1:0] w_count_nxt;
    logic [PSC_W-1:0] w_psc_nxt;
    logic             w_tc_nxt;
    logic             w_done_nxt;
    logic             w_ovf_evt;
    logic             w_ovf_nxt;

    // Next-state logic: load overrides any tick; wrap happens only via TOP/0 compares.
    always_comb begin
        w_tick      = ena && (r_psc == PSC_LAST);
        w_count_nxt = r_count;
        w_psc_nxt   = r_psc;
        w_tc_nxt    = 1'b0;
        w_done_nxt  = r_done;
        w_ovf_evt   = 1'b0;
        if (load) begin
            w_count_nxt = (load_value > TOP_V) ? TOP_V : load_value;
            w_psc_nxt   = PSC_ZERO;
            w_done_nxt  = 1'b0;
        end else begin
            if (ena) begin
                w_psc_nxt = w_tick ? PSC_ZERO : (r_psc + PSC_ONE);
            end else begin
                w_psc_nxt = r_psc;
            end
            if (w_tick) begin
                case (mode)
                    MODE_UP_WRAP: begin
                        if (r_count == TOP_V) begin
                            w_count_nxt = ZERO_V;
                            w_tc_nxt    = 1'b1;
                            w_ovf_evt   = 1'b1;
                        end else begin
                            w_count_nxt = r_count + ONE_V;
                        end
                    end
                    MODE_DOWN_WRAP: begin
                        if (r_count == ZERO_V) begin
                            w_count_nxt = TOP_V;
                            w_tc_nxt    = 1'b1;
                            w_ovf_evt   = 1'b1;
                        end else begin
                            w_count_nxt = r_count - ONE_V;
                        end
                    end
                    MODE_UP_SAT: begin
                        if (r_count < TOP_V) begin
                            w_count_nxt = r_count + ONE_V;
                            w_tc_nxt    = ((r_count + ONE_V) == TOP_V);
                        end else begin
                            w_ovf_evt   = 1'b1;
                        end
                    end
                    MODE_ONESHOT: begin
                        if (r_count > ONE_V) begin
                            w_count_nxt = r_count - ONE_V;
                        end else if (r_count == ONE_V) begin
                            w_count_nxt = ZERO_V;
                            w_tc_nxt    = 1'b1;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_done_nxt  = 1'b1;
                        end
                    end
                    default: begin
                        w_count_nxt = r_count;
                    end
                endcase
            end else begin
                w_count_nxt = r_count;
            end
        end
        // A same-cycle overflow event beats the clear request.
        if (w_ovf_evt) begin
            w_ovf_nxt = 1'b1;
        end else if (clr_ovf) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_ovf;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= ZERO_V;
            r_psc   <= PSC_ZERO;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_psc   <= w_psc_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;
    assign done  = r_done;

endmodule
